// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: op codes, FSM encoding and
// op-class helpers used by both the top level and the bench-facing ports.
package alu_pkg;

    localparam logic [3:0] OP_ADD   = 4'h0;
    localparam logic [3:0] OP_SUB   = 4'h1;
    localparam logic [3:0] OP_AND   = 4'h2;
    localparam logic [3:0] OP_OR    = 4'h3;
    localparam logic [3:0] OP_XOR   = 4'h4;
    localparam logic [3:0] OP_SLT   = 4'h5;
    localparam logic [3:0] OP_SLTU  = 4'h6;
    localparam logic [3:0] OP_SLL   = 4'h7;
    localparam logic [3:0] OP_SRL   = 4'h8;
    localparam logic [3:0] OP_SRA   = 4'h9;
    localparam logic [3:0] OP_MUL   = 4'hA;
    localparam logic [3:0] OP_MULHU = 4'hB;
    localparam logic [3:0] OP_DIVU  = 4'hC;
    localparam logic [3:0] OP_REMU  = 4'hD;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;

    // MUL, MULHU, DIVU, REMU run through the shift/subtract engine
    function automatic logic is_iterative(input logic [3:0] op);
        return (op >= OP_MUL) && (op <= OP_REMU);
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return (op == OP_DIVU) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/seq_muldiv.sv
// Iterative unsigned multiply / restoring divide engine, one bit per clock.
// r_hi is the product high half or the partial remainder; r_lo starts as
// the multiplier/dividend and fills with product low bits/quotient bits.
// The next-state values are exported so the final step can be written to
// the result register on the same edge the counter reaches zero.
module seq_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic             i_step,
    input  logic             i_is_div,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_last,
    output logic [WIDTH-1:0] o_hi_nxt,
    output logic [WIDTH-1:0] o_lo_nxt
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic [CNT_W-1:0] r_cnt;
    logic             r_is_div;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_opnd;

    logic [WIDTH:0]   w_add;
    logic [WIDTH:0]   w_shl;
    logic [WIDTH-1:0] w_diff;
    logic             w_ge;

    // One step of either shift-add multiply or restoring division
    always_comb begin
        w_add  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
        w_shl  = {r_hi, r_lo[WIDTH-1]};
        w_ge   = (w_shl >= {1'b0, r_opnd});
        // only used when w_ge, where the true difference fits in WIDTH bits
        w_diff = w_shl[WIDTH-1:0] - r_opnd;
        if (r_is_div) begin
            o_hi_nxt = w_ge ? w_diff : w_shl[WIDTH-1:0];
            o_lo_nxt = {r_lo[WIDTH-2:0], w_ge};
        end else begin
            o_hi_nxt = w_add[WIDTH:1];
            o_lo_nxt = {w_add[0], r_lo[WIDTH-1:1]};
        end
    end

    assign o_last = i_step && (r_cnt == CNT_W'(1));

    // Operand latch on load, then WIDTH iterations while stepping
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_opnd   <= '0;
        end else if (i_load) begin
            r_cnt    <= CNT_W'(WIDTH);
            r_is_div <= i_is_div;
            r_hi     <= '0;
            r_lo     <= i_a;
            r_opnd   <= i_b;
        end else if (i_step && (r_cnt != '0)) begin
            r_cnt    <= r_cnt - CNT_W'(1);
            r_hi     <= o_hi_nxt;
            r_lo     <= o_lo_nxt;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Multicycle ALU: single-cycle logic/arith/shift ops plus iterative
// unsigned MUL/MULHU/DIVU/REMU behind a start/busy/done handshake.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             negative,
    output logic             carry,
    output logic             overflow
);

    localparam int SHAMT_W = $clog2(WIDTH);

    logic [1:0]       r_state;
    logic [3:0]       r_op;
    logic [WIDTH-1:0] r_result;
    logic             r_carry;
    logic             r_overflow;
    logic             r_done;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_dif;
    logic [SHAMT_W-1:0] w_shamt;
    logic [WIDTH-1:0] w_fast_res;
    logic             w_fast_c;
    logic             w_fast_v;
    logic             w_idle;
    logic             w_load;
    logic             w_step;
    logic             w_last;
    logic             w_sel_lo;
    logic [WIDTH-1:0] w_hi_nxt;
    logic [WIDTH-1:0] w_lo_nxt;

    assign w_idle   = (r_state == ST_IDLE);
    // divide by zero never enters the engine; it finishes like a fast op
    assign w_load   = w_idle && start && is_iterative(op) &&
                      !(is_div(op) && (src_b == '0));
    assign w_step   = !w_idle;
    assign w_sel_lo = (r_op == OP_MUL) || (r_op == OP_DIVU);

    // Single-cycle datapath and ADD/SUB flags
    always_comb begin
        w_sum      = {1'b0, src_a} + {1'b0, src_b};
        w_dif      = {1'b0, src_a} + {1'b0, ~src_b} + {{WIDTH{1'b0}}, 1'b1};
        w_shamt    = src_b[SHAMT_W-1:0];
        w_fast_res = '0;
        w_fast_c   = 1'b0;
        w_fast_v   = 1'b0;
        case (op)
            OP_ADD: begin
                w_fast_res = w_sum[WIDTH-1:0];
                w_fast_c   = w_sum[WIDTH];
                w_fast_v   = (src_a[WIDTH-1] == src_b[WIDTH-1]) &&
                             (w_sum[WIDTH-1] != src_a[WIDTH-1]);
            end
            OP_SUB: begin
                w_fast_res = w_dif[WIDTH-1:0];
                w_fast_c   = w_dif[WIDTH];
                w_fast_v   = (src_a[WIDTH-1] != src_b[WIDTH-1]) &&
                             (w_dif[WIDTH-1] != src_a[WIDTH-1]);
            end
            OP_AND:   w_fast_res = src_a & src_b;
            OP_OR:    w_fast_res = src_a | src_b;
            OP_XOR:   w_fast_res = src_a ^ src_b;
            OP_SLT:   w_fast_res = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            OP_SLTU:  w_fast_res = {{(WIDTH-1){1'b0}}, (src_a < src_b)};
            OP_SLL:   w_fast_res = src_a << w_shamt;
            OP_SRL:   w_fast_res = src_a >> w_shamt;
            OP_SRA:   w_fast_res = $signed(src_a) >>> w_shamt;
            OP_DIVU:  w_fast_res = '1;
            OP_REMU:  w_fast_res = src_a;
            OP_MUL, OP_MULHU: w_fast_res = '0;
            default:  w_fast_res = '0;
        endcase
    end

    seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk      (clk),
        .reset    (reset),
        .i_load   (w_load),
        .i_step   (w_step),
        .i_is_div (is_div(op)),
        .i_a      (src_a),
        .i_b      (src_b),
        .o_last   (w_last),
        .o_hi_nxt (w_hi_nxt),
        .o_lo_nxt (w_lo_nxt)
    );

    // Control FSM: result/flags written only on completion, done pulses once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_op       <= OP_ADD;
            r_result   <= '0;
            r_carry    <= 1'b0;
            r_overflow <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_load) begin
                        r_op    <= op;
                        r_state <= is_div(op) ? ST_DIV : ST_MUL;
                    end else if (start) begin
                        r_result   <= w_fast_res;
                        r_carry    <= w_fast_c;
                        r_overflow <= w_fast_v;
                        r_done     <= 1'b1;
                    end
                end
                ST_MUL, ST_DIV: begin
                    if (w_last) begin
                        r_result   <= w_sel_lo ? w_lo_nxt : w_hi_nxt;
                        r_carry    <= 1'b0;
                        r_overflow <= 1'b0;
                        r_done     <= 1'b1;
                        r_state    <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy     = !w_idle;
    assign done     = r_done;
    assign result   = r_result;
    assign carry    = r_carry;
    assign overflow = r_overflow;
    assign zero     = (r_result == '0);
    assign negative = r_result[WIDTH-1];

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: a 32-bit instance for the main checks and
// an 8-bit instance for the narrow multiply/divide case.
module tb_seq_alu;

    typedef struct packed {
        logic [31:0] res;
        logic        z;
        logic        n;
        logic        c;
        logic        v;
        logic [7:0]  lat;
    } obs_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, start8;
    logic [3:0]  op, op8;
    logic [31:0] a, b;
    logic [7:0]  a8, b8;
    logic        busy, done, zero, negative, carry, overflow;
    logic [31:0] result;
    logic        busy8, done8, zero8, negative8, carry8, overflow8;
    logic [7:0]  result8;

    obs_t exp_q[$];
    obs_t obs, ex;
    logic busy_ok;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .src_a(a), .src_b(b),
        .busy(busy), .done(done), .result(result), .zero(zero),
        .negative(negative), .carry(carry), .overflow(overflow)
    );

    seq_alu #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .op(op8), .src_a(a8), .src_b(b8),
        .busy(busy8), .done(done8), .result(result8), .zero(zero8),
        .negative(negative8), .carry(carry8), .overflow(overflow8)
    );

    function automatic obs_t mk(input logic [31:0] r, input logic c, input logic v,
                                input int lat, input int w);
        obs_t o;
        o.res = r;
        o.z   = (r == 32'h0);
        o.n   = (w == 8) ? r[7] : r[31];
        o.c   = c;
        o.v   = v;
        o.lat = 8'(lat);
        return o;
    endfunction

    task automatic capture(input bit w8);
        obs.res = w8 ? {24'h0, result8} : result;
        obs.z   = w8 ? zero8 : zero;
        obs.n   = w8 ? negative8 : negative;
        obs.c   = w8 ? carry8 : carry;
        obs.v   = w8 ? overflow8 : overflow;
    endtask

    // drive one start, then wait (bounded) for done; lat counts edges after the start edge
    task automatic xact(input bit w8, input logic [3:0] o, input logic [31:0] aa,
                        input logic [31:0] bb);
        if (w8) begin
            start8 = 1'b1; op8 = o; a8 = aa[7:0]; b8 = bb[7:0];
        end else begin
            start = 1'b1; op = o; a = aa; b = bb;
        end
        @(posedge clk); #1;
        start = 1'b0; start8 = 1'b0;
        obs.lat = 8'd0;
        busy_ok = 1'b1;
        while (((w8 ? done8 : done) !== 1'b1) && (obs.lat < 8'd100)) begin
            if ((w8 ? busy8 : busy) !== 1'b1) busy_ok = 1'b0;
            @(posedge clk); #1;
            obs.lat = obs.lat + 8'd1;
        end
        capture(w8);
    endtask

    task automatic test_reset();
        #3;
        vectors++;
        if ({busy, done, result, zero, negative, carry, overflow} !== {2'b00, 32'h0, 4'b1000}) begin
            miscompares++;
            $display("FAIL reset32: got busy=%b done=%b res=%h znvc=%b%b%b%b, want 0 0 0 1000",
                     busy, done, result, zero, negative, carry, overflow);
        end
        vectors++;
        if ({busy8, done8, result8, zero8, negative8, carry8, overflow8} !== {2'b00, 8'h0, 4'b1000}) begin
            miscompares++;
            $display("FAIL reset8: got busy=%b done=%b res=%h, want 0 0 00", busy8, done8, result8);
        end
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        // give result a nonzero value so the async clear is visible
        exp_q.push_back(mk(32'd7, 1'b0, 1'b0, 0, 32));
        xact(1'b0, 4'h0, 32'd3, 32'd4);
        ex = exp_q.pop_front();
        vectors++;
        if (obs !== ex) begin
            miscompares++;
            $display("FAIL pre_reset_add: got res=%h lat=%0d, want res=%h lat=%0d", obs.res, obs.lat, ex.res, ex.lat);
        end
        start = 1'b1; op = 4'hA; a = 32'hFFFF_FFFF; b = 32'd2;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL mul_busy_before_reset: got %b, want 1", busy);
        end
        #2 reset = 1'b1;
        #1;
        vectors++;
        if ({busy, done, result, zero, carry, overflow} !== {2'b00, 32'h0, 3'b100}) begin
            miscompares++;
            $display("FAIL async_reset: got busy=%b done=%b res=%h zero=%b, want 0 0 0 1", busy, done, result, zero);
        end
        #2 reset = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done !== 1'b0 || busy !== 1'b0) begin
                vectors++;
                miscompares++;
                $display("FAIL aborted_mul: got done=%b busy=%b, want 0 0", done, busy);
            end
        end
        exp_q.push_back(mk(32'd2, 1'b0, 1'b0, 0, 32));
        xact(1'b0, 4'h0, 32'd1, 32'd1);
        ex = exp_q.pop_front();
        vectors++;
        if (obs !== ex) begin
            miscompares++;
            $display("FAIL post_reset_add: got res=%h lat=%0d, want res=%h lat=%0d", obs.res, obs.lat, ex.res, ex.lat);
        end
    endtask

    task automatic test_fast();
        logic [3:0]  t_op[18] = '{4'h0, 4'h1, 4'h0, 4'h1, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5,
                                  4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hE, 4'hF, 4'hC, 4'hD};
        logic [31:0] t_a[18]  = '{32'h7FFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'd1, 32'h8000_0000,
                                  32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'd1,
                                  32'hFFFF_FFFF, 32'd1, 32'd1, 32'h8000_0000, 32'h8000_0000,
                                  32'd5, 32'hFFFF_FFFF, 32'd1234, 32'd9};
        logic [31:0] t_b[18]  = '{32'd1, 32'd5, 32'd1, 32'd2, 32'd1,
                                  32'hFF00_FF00, 32'hFF00_FF00, 32'hFF00_FF00, 32'hFFFF_FFFF,
                                  32'd1, 32'hFFFF_FFFF, 32'h3F, 32'h21, 32'h24,
                                  32'd5, 32'd1, 32'd0, 32'd0};
        logic [31:0] t_r[18]  = '{32'h8000_0000, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h7FFF_FFFF,
                                  32'hF000_F000, 32'hFFF0_FFF0, 32'h0FF0_0FF0, 32'd0,
                                  32'd1, 32'd1, 32'h8000_0000, 32'h4000_0000, 32'hF800_0000,
                                  32'h0, 32'h0, 32'hFFFF_FFFF, 32'd9};
        logic [1:0]  t_cv[18] = '{2'b01, 2'b10, 2'b10, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00,
                                  2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        for (int i = 0; i < 18; i++) begin
            exp_q.push_back(mk(t_r[i], t_cv[i][1], t_cv[i][0], 0, 32));
            xact(1'b0, t_op[i], t_a[i], t_b[i]);
            ex = exp_q.pop_front();
            vectors++;
            if (obs !== ex) begin
                miscompares++;
                $display("FAIL fast[%0d] op=%h: got res=%h znvc=%b%b%b%b lat=%0d, want res=%h znvc=%b%b%b%b lat=%0d",
                         i, t_op[i], obs.res, obs.z, obs.n, obs.c, obs.v, obs.lat,
                         ex.res, ex.z, ex.n, ex.c, ex.v, ex.lat);
            end
        end
        // done is a single-cycle pulse and result holds afterwards
        @(posedge clk); #1;
        vectors++;
        if ({done, result} !== {1'b0, 32'd9}) begin
            miscompares++;
            $display("FAIL done_pulse: got done=%b res=%h, want 0 00000009", done, result);
        end
    endtask

    task automatic test_iter();
        logic [3:0]  i_op[8];
        logic [31:0] i_a[8];
        logic [31:0] i_b[8];
        logic [63:0] prod;
        i_op[0] = 4'hA; i_a[0] = 32'hFFFF_FFFF; i_b[0] = 32'd2;
        i_op[1] = 4'hB; i_a[1] = 32'hFFFF_FFFF; i_b[1] = 32'd2;
        i_op[2] = 4'hC; i_a[2] = 32'd100;       i_b[2] = 32'd7;
        i_op[3] = 4'hD; i_a[3] = 32'd100;       i_b[3] = 32'd7;
        for (int i = 4; i < 8; i++) begin
            i_op[i] = 4'(4'hA + (i - 4));
            i_a[i]  = $urandom;
            i_b[i]  = (i >= 6) ? 32'($urandom_range(1, 100000)) : $urandom;
        end
        for (int i = 0; i < 8; i++) begin
            prod = 64'(i_a[i]) * 64'(i_b[i]);
            case (i_op[i])
                4'hA:    exp_q.push_back(mk(prod[31:0], 1'b0, 1'b0, 32, 32));
                4'hB:    exp_q.push_back(mk(prod[63:32], 1'b0, 1'b0, 32, 32));
                4'hC:    exp_q.push_back(mk(i_a[i] / i_b[i], 1'b0, 1'b0, 32, 32));
                default: exp_q.push_back(mk(i_a[i] % i_b[i], 1'b0, 1'b0, 32, 32));
            endcase
            xact(1'b0, i_op[i], i_a[i], i_b[i]);
            ex = exp_q.pop_front();
            vectors++;
            if (obs !== ex || busy_ok !== 1'b1) begin
                miscompares++;
                $display("FAIL iter[%0d] op=%h a=%h b=%h: got res=%h lat=%0d busy_ok=%b, want res=%h lat=%0d busy_ok=1",
                         i, i_op[i], i_a[i], i_b[i], obs.res, obs.lat, busy_ok, ex.res, ex.lat);
            end
        end
    endtask

    task automatic test_busy_ignore();
        logic held_ok;
        exp_q.push_back(mk(32'h55, 1'b0, 1'b0, 0, 32));
        xact(1'b0, 4'h0, 32'h50, 32'h5);
        ex = exp_q.pop_front();
        vectors++;
        if (obs !== ex) begin
            miscompares++;
            $display("FAIL ignore_setup: got res=%h, want res=%h", obs.res, ex.res);
        end
        exp_q.push_back(mk(32'd14, 1'b0, 1'b0, 32, 32));
        start = 1'b1; op = 4'hC; a = 32'd100; b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        obs.lat = 8'd0;
        held_ok = 1'b1;
        while (done !== 1'b1 && obs.lat < 8'd100) begin
            if (obs.lat == 8'd5) begin
                start = 1'b1; op = 4'h0; a = 32'd1; b = 32'd1;
            end else begin
                start = 1'b0;
            end
            if (result !== 32'h55 || busy !== 1'b1) held_ok = 1'b0;
            @(posedge clk); #1;
            obs.lat = obs.lat + 8'd1;
        end
        start = 1'b0;
        capture(1'b0);
        ex = exp_q.pop_front();
        vectors++;
        if (obs !== ex || held_ok !== 1'b1) begin
            miscompares++;
            $display("FAIL start_while_busy: got res=%h lat=%0d held=%b, want res=%h lat=%0d held=1",
                     obs.res, obs.lat, held_ok, ex.res, ex.lat);
        end
    endtask

    task automatic test_back_to_back();
        // second start is driven in the done cycle of the first
        exp_q.push_back(mk(32'd15, 1'b0, 1'b0, 32, 32));
        exp_q.push_back(mk(32'd30, 1'b0, 1'b0, 0, 32));
        exp_q.push_back(mk(32'd4, 1'b0, 1'b0, 32, 32));
        xact(1'b0, 4'hA, 32'd3, 32'd5);
        ex = exp_q.pop_front();
        vectors++;
        if (obs !== ex) begin
            miscompares++;
            $display("FAIL b2b_mul: got res=%h lat=%0d, want res=%h lat=%0d", obs.res, obs.lat, ex.res, ex.lat);
        end
        xact(1'b0, 4'h0, 32'd10, 32'd20);
        ex = exp_q.pop_front();
        vectors++;
        if (obs !== ex) begin
            miscompares++;
            $display("FAIL b2b_add: got res=%h lat=%0d, want res=%h lat=%0d", obs.res, obs.lat, ex.res, ex.lat);
        end
        xact(1'b0, 4'hD, 32'd34, 32'd6);
        ex = exp_q.pop_front();
        vectors++;
        if (obs !== ex) begin
            miscompares++;
            $display("FAIL b2b_remu: got res=%h lat=%0d, want res=%h lat=%0d", obs.res, obs.lat, ex.res, ex.lat);
        end
    endtask

    task automatic test_w8();
        logic [3:0] w_op[4] = '{4'hA, 4'hB, 4'hC, 4'hD};
        logic [7:0] w_a[4]  = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
        logic [7:0] w_b[4]  = '{8'hFF, 8'hFF, 8'h10, 8'h10};
        logic [7:0] w_r[4]  = '{8'h01, 8'hFE, 8'h0F, 8'h0F};
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(mk({24'h0, w_r[i]}, 1'b0, 1'b0, 8, 8));
            xact(1'b1, w_op[i], {24'h0, w_a[i]}, {24'h0, w_b[i]});
            ex = exp_q.pop_front();
            vectors++;
            if (obs !== ex || busy_ok !== 1'b1) begin
                miscompares++;
                $display("FAIL w8[%0d] op=%h: got res=%h n=%b lat=%0d busy_ok=%b, want res=%h n=%b lat=%0d busy_ok=1",
                         i, w_op[i], obs.res, obs.n, obs.lat, busy_ok, ex.res, ex.n, ex.lat);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0; op = 4'h0; a = 32'h0; b = 32'h0;
        start8 = 1'b0; op8 = 4'h0; a8 = 8'h0; b8 = 8'h0;
        test_reset();
        test_fast();
        test_iter();
        test_busy_ignore();
        test_back_to_back();
        test_w8();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
